// File: rtl/dpram_burst_arbiter.sv
// Two-requester burst arbiter in front of one port of a dual-port RAM.
// It grants round-robin, runs one burst at a time (IDLE -> BURST -> DONE) and
// issues one RAM beat per BURST cycle.
module dpram_burst_arbiter #(
  parameter int unsigned AWIDTH = 10,
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned LWIDTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_0,
  input  logic              req_1,
  input  logic              we_0,
  input  logic              we_1,
  input  logic [AWIDTH-1:0] addr_0,
  input  logic [AWIDTH-1:0] addr_1,
  input  logic [LWIDTH-1:0] len_0,
  input  logic [LWIDTH-1:0] len_1,
  input  logic [DWIDTH-1:0] wdata_0,
  input  logic [DWIDTH-1:0] wdata_1,
  output logic              gnt_0,
  output logic              gnt_1,
  output logic              wrdy_0,
  output logic              wrdy_1,
  output logic [DWIDTH-1:0] rdata,
  output logic              rvld_0,
  output logic              rvld_1,
  output logic              done_0,
  output logic              done_1,
  output logic [AWIDTH-1:0] ram_addr,
  output logic              ram_wren,
  output logic [DWIDTH-1:0] ram_wdata,
  input  logic [DWIDTH-1:0] ram_rdata
);

  typedef enum logic [1:0] {StIdle, StBurst, StDone} state_e;

  state_e              state_q;
  logic                owner_q;  // requester that owns the current burst
  logic                prio_q;   // requester that wins when both ask
  logic                we_q;
  logic [LWIDTH-1:0]   len_q;
  logic [LWIDTH-1:0]   beat_q;
  logic [AWIDTH-1:0]   addr_q;
  logic [1:0]          gnt_q;
  logic [1:0]          rvld_q;
  logic                done_q;
  logic                sel;
  logic                in_burst;

  // Round-robin pick: a lone requester wins outright, otherwise the priority holder.
  always_comb begin
    sel = prio_q;
    if (req_0 && !req_1) begin
      sel = 1'b0;
    end else if (!req_0 && req_1) begin
      sel = 1'b1;
    end
  end

  // Burst FSM with registered grant, read-valid and done pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      we_q    <= 1'b0;
      len_q   <= '0;
      beat_q  <= '0;
      addr_q  <= '0;
      gnt_q   <= '0;
      rvld_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      gnt_q  <= '0;
      rvld_q <= '0;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_0 || req_1) begin
            owner_q <= sel;
            we_q    <= sel ? we_1 : we_0;
            addr_q  <= sel ? addr_1 : addr_0;
            len_q   <= sel ? len_1 : len_0;
            beat_q  <= '0;
            gnt_q   <= sel ? 2'b10 : 2'b01;
            state_q <= StBurst;
          end
        end
        StBurst: begin
          // Read data appears one cycle after the beat, so flag it for next cycle.
          if (!we_q) begin
            rvld_q[owner_q] <= 1'b1;
          end
          if (beat_q == len_q) begin
            // Address is left on the last beat so ram_addr holds it outside BURST.
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            beat_q <= beat_q + LWIDTH'(1);
            addr_q <= addr_q + AWIDTH'(1);
          end
        end
        StDone: begin
          prio_q  <= ~owner_q;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_burst  = (state_q == StBurst);
  assign gnt_0     = gnt_q[0];
  assign gnt_1     = gnt_q[1];
  assign rvld_0    = rvld_q[0];
  assign rvld_1    = rvld_q[1];
  assign done_0    = done_q & ~owner_q;
  assign done_1    = done_q & owner_q;
  assign ram_wren  = in_burst & we_q;
  assign wrdy_0    = in_burst & we_q & ~owner_q;
  assign wrdy_1    = in_burst & we_q & owner_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = in_burst ? (owner_q ? wdata_1 : wdata_0) : '0;
  assign rdata     = ram_rdata;

endmodule

// File: tb/tb_dpram_burst_arbiter.sv
// Directed bench: DUT plus a behavioural 1-cycle-read RAM, checked cycle by cycle.
module tb_dpram_burst_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 4;

  // Control-bit weights for the packed status word.
  localparam logic [8:0] WREN = 9'd1;
  localparam logic [8:0] D0   = 9'd2;
  localparam logic [8:0] D1   = 9'd4;
  localparam logic [8:0] V0   = 9'd8;
  localparam logic [8:0] V1   = 9'd16;
  localparam logic [8:0] W0   = 9'd32;
  localparam logic [8:0] W1   = 9'd64;
  localparam logic [8:0] G0   = 9'd128;
  localparam logic [8:0] G1   = 9'd256;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_0, req_1, we_0, we_1;
  logic [AW-1:0] addr_0, addr_1;
  logic [LW-1:0] len_0, len_1;
  logic [DW-1:0] wdata_0, wdata_1;
  logic          gnt_0, gnt_1, wrdy_0, wrdy_1, rvld_0, rvld_1, done_0, done_1;
  logic [DW-1:0] rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_wren;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // RAM port: write on wren, otherwise registered read.
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    else ram_rdata <= mem[ram_addr];
  end

  dpram_burst_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .LWIDTH(LW)) dut (
    .clk(clk), .reset(reset),
    .req_0(req_0), .req_1(req_1), .we_0(we_0), .we_1(we_1),
    .addr_0(addr_0), .addr_1(addr_1), .len_0(len_0), .len_1(len_1),
    .wdata_0(wdata_0), .wdata_1(wdata_1),
    .gnt_0(gnt_0), .gnt_1(gnt_1), .wrdy_0(wrdy_0), .wrdy_1(wrdy_1),
    .rdata(rdata), .rvld_0(rvld_0), .rvld_1(rvld_1),
    .done_0(done_0), .done_1(done_1),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  function automatic logic [8:0] ctl();
    return {gnt_1, gnt_0, wrdy_1, wrdy_0, rvld_1, rvld_0, done_1, done_0, ram_wren};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; req_0 = 0; req_1 = 0; we_0 = 0; we_1 = 0;
    addr_0 = '0; addr_1 = '0; len_0 = '0; len_1 = '0; wdata_0 = '0; wdata_1 = '0;
    next(); next(); #1;
    chk("rst_ctl", 32'(ctl()), 32'(9'd0));
    chk("rst_addr", 32'(ram_addr), 32'h0);
    chk("rst_wdata", ram_wdata, 32'h0);
    reset = 1'b0;

    // Single write with address wrap.
    req_0 = 1; we_0 = 1; addr_0 = 10'h3FE; len_0 = 4'd2; wdata_0 = 32'hA;
    next(); #1;
    chk("wr_b0_ctl", 32'(ctl()), 32'(G0 | W0 | WREN));
    chk("wr_b0_addr", 32'(ram_addr), 32'h3FE);
    chk("wr_b0_data", ram_wdata, 32'hA);
    req_0 = 0;
    next(); wdata_0 = 32'hB; #1;
    chk("wr_b1_ctl", 32'(ctl()), 32'(W0 | WREN));
    chk("wr_b1_addr", 32'(ram_addr), 32'h3FF);
    chk("wr_b1_data", ram_wdata, 32'hB);
    next(); wdata_0 = 32'hC; #1;
    chk("wr_b2_ctl", 32'(ctl()), 32'(W0 | WREN));
    chk("wr_b2_addr", 32'(ram_addr), 32'h000);
    chk("wr_b2_data", ram_wdata, 32'hC);
    next(); #1;
    chk("wr_done_ctl", 32'(ctl()), 32'(D0));
    chk("wr_done_addr", 32'(ram_addr), 32'h000);
    next(); #1;
    chk("wr_idle_ctl", 32'(ctl()), 32'(9'd0));

    // Read back through requester 1.
    req_1 = 1; we_1 = 0; addr_1 = 10'h3FE; len_1 = 4'd2;
    next(); #1;
    chk("rd_gnt_ctl", 32'(ctl()), 32'(G1));
    chk("rd_b0_addr", 32'(ram_addr), 32'h3FE);
    req_1 = 0;
    next(); #1;
    chk("rd_v0_ctl", 32'(ctl()), 32'(V1));
    chk("rd_v0_data", rdata, 32'hA);
    next(); #1;
    chk("rd_v1_ctl", 32'(ctl()), 32'(V1));
    chk("rd_v1_data", rdata, 32'hB);
    next(); #1;
    chk("rd_v2_ctl", 32'(ctl()), 32'(V1 | D1));
    chk("rd_v2_data", rdata, 32'hC);
    next(); #1;
    chk("rd_idle_ctl", 32'(ctl()), 32'(9'd0));

    // Contention from reset with len=0 reads: 0, 1, 0 with 3-cycle spacing.
    reset = 1; next(); reset = 0;
    req_0 = 1; req_1 = 1; we_0 = 0; we_1 = 0;
    addr_0 = 10'h010; addr_1 = 10'h020; len_0 = 4'd0; len_1 = 4'd0;
    next(); #1;
    chk("ct_g0_ctl", 32'(ctl()), 32'(G0));
    chk("ct_g0_addr", 32'(ram_addr), 32'h010);
    next(); #1;
    chk("ct_d0_ctl", 32'(ctl()), 32'(V0 | D0));
    next(); #1;
    chk("ct_idle1_ctl", 32'(ctl()), 32'(9'd0));
    next(); #1;
    chk("ct_g1_ctl", 32'(ctl()), 32'(G1));
    chk("ct_g1_addr", 32'(ram_addr), 32'h020);
    next(); #1;
    chk("ct_d1_ctl", 32'(ctl()), 32'(V1 | D1));
    next(); #1;
    chk("ct_idle2_ctl", 32'(ctl()), 32'(9'd0));
    next(); #1;
    chk("ct_g0b_ctl", 32'(ctl()), 32'(G0));
    req_0 = 0; req_1 = 0;
    next(); #1;
    chk("ct_d0b_ctl", 32'(ctl()), 32'(V0 | D0));
    next(); #1;
    chk("ct_idle3_ctl", 32'(ctl()), 32'(9'd0));

    // len=15 write; owner drops req, non-owner request arrives mid-burst and waits.
    req_0 = 1; we_0 = 1; addr_0 = 10'h100; len_0 = 4'd15;
    for (int k = 0; k < 16; k++) begin
      next(); wdata_0 = 32'h1000 + 32'(k); #1;
      chk("l15_ctl", 32'(ctl()), 32'((k == 0) ? (G0 | W0 | WREN) : (W0 | WREN)));
      chk("l15_addr", 32'(ram_addr), 32'h100 + 32'(k));
      req_0 = 0;
      if (k == 5) begin
        req_1 = 1; we_1 = 0; addr_1 = 10'h3FE; len_1 = 4'd0;
      end
    end
    next(); #1;
    chk("l15_done_ctl", 32'(ctl()), 32'(D0));
    next(); #1;
    chk("l15_idle_ctl", 32'(ctl()), 32'(9'd0));
    next(); #1;
    chk("wait_g1_ctl", 32'(ctl()), 32'(G1));
    req_1 = 0;
    next(); #1;
    chk("wait_d1_ctl", 32'(ctl()), 32'(V1 | D1));
    chk("wait_d1_data", rdata, 32'hA);
    next(); #1;
    chk("wait_idle_ctl", 32'(ctl()), 32'(9'd0));

    // Reset during the 3rd beat of a len=7 overwrite of 0x100.
    req_0 = 1; we_0 = 1; addr_0 = 10'h100; len_0 = 4'd7;
    next(); wdata_0 = 32'h2000; #1;
    chk("ab_b0_ctl", 32'(ctl()), 32'(G0 | W0 | WREN));
    req_0 = 0;
    next(); wdata_0 = 32'h2001; #1;
    chk("ab_b1_ctl", 32'(ctl()), 32'(W0 | WREN));
    next(); wdata_0 = 32'h2002; #1;
    chk("ab_b2_addr", 32'(ram_addr), 32'h102);
    reset = 1;
    next(); #1;
    chk("ab_rst_ctl", 32'(ctl()), 32'(9'd0));
    chk("ab_rst_addr", 32'(ram_addr), 32'h0);
    reset = 0;
    next(); #1;
    chk("ab_nodone_ctl", 32'(ctl()), 32'(9'd0));

    // Read back 0x100..0x107: beats 0-2 from the aborted burst, rest from the len=15 burst.
    req_1 = 1; we_1 = 0; addr_1 = 10'h100; len_1 = 4'd7;
    next(); #1;
    chk("rb_gnt_ctl", 32'(ctl()), 32'(G1));
    req_1 = 0;
    for (int k = 0; k < 8; k++) begin
      next(); #1;
      chk("rb_ctl", 32'(ctl()), 32'((k == 7) ? (V1 | D1) : V1));
      chk("rb_data", rdata, (k < 3) ? (32'h2000 + 32'(k)) : (32'h1000 + 32'(k)));
    end
    next(); #1;
    chk("rb_idle_ctl", 32'(ctl()), 32'(9'd0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dpram_burst_arbiter.md
DPRAM_BURST_ARBITER -- requirements
Module: dpram_burst_arbiter

Interface
REQ-001 The block SHALL have parameter AWIDTH, default 10, RAM address width.
REQ-002 The block SHALL have parameter DWIDTH, default 32, RAM data width.
REQ-003 The block SHALL have parameter LWIDTH, default 4, burst-length field width; a burst is len+1 beats (1..2^LWIDTH).
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-006 The block SHALL have ports req_0/req_1, input, 1 bit each, burst request held until granted.
REQ-007 The block SHALL have ports we_0/we_1, input, 1 bit each: 1 = write burst, 0 = read burst.
REQ-008 The block SHALL have ports addr_0/addr_1, input, AWIDTH each, burst start address.
REQ-009 The block SHALL have ports len_0/len_1, input, LWIDTH each, burst length minus one.
REQ-010 The block SHALL have ports wdata_0/wdata_1, input, DWIDTH each, write beat data.
REQ-011 The block SHALL have ports gnt_0/gnt_1, output, 1 bit each, one-cycle grant pulse.
REQ-012 The block SHALL have ports wrdy_0/wrdy_1, output, 1 bit each: wdata consumed this cycle.
REQ-013 The block SHALL have port rdata, output, DWIDTH, shared read data, equal to ram_rdata.
REQ-014 The block SHALL have ports rvld_0/rvld_1, output, 1 bit each, rdata valid for that requester.
REQ-015 The block SHALL have ports done_0/done_1, output, 1 bit each, one-cycle burst-complete pulse.
REQ-016 The block SHALL have ports ram_addr (output, AWIDTH), ram_wren (output, 1), ram_wdata (output, DWIDTH) and ram_rdata (input, DWIDTH), driving one port of a dual-port RAM with 1-cycle registered read that does not update read data on write cycles.

Function
REQ-017 The FSM SHALL have states IDLE, BURST, DONE.
REQ-018 In IDLE with any req high, the block SHALL select an owner, latch its we/addr/len, and enter BURST next cycle; with no req it SHALL remain in IDLE.
REQ-019 Arbitration SHALL be round-robin: when both request, the requester not served by the last completed grant wins; after reset requester 0 has priority.
REQ-020 gnt_<owner> SHALL pulse high for exactly the first BURST cycle; the requester SHALL hold req fields stable until gnt and SHALL drop or renew req after it.
REQ-021 Each BURST cycle SHALL issue one beat: ram_addr = current address, ram_wren = latched we, ram_wdata = wdata_<owner>, wrdy_<owner> = latched we.
REQ-022 The current address SHALL increment by 1 per beat modulo 2^AWIDTH (wrap from all-ones to 0).
REQ-023 After the beat count reaches len+1, the FSM SHALL enter DONE; DONE SHALL last one cycle, pulse done_<owner>, then return to IDLE.
REQ-024 For read bursts, rvld_<owner> SHALL be high in the cycle after each read beat, so exactly len+1 rvld cycles, the last coinciding with DONE.
REQ-025 Minimum spacing SHALL be one IDLE cycle between DONE and the next grant; a burst of L beats occupies L+2 cycles (IDLE, L BURST, DONE).
REQ-026 Outside BURST, ram_wren, all wrdy, gnt, rvld (except the DONE read beat) SHALL be 0; ram_addr SHALL hold its last value.
REQ-027 Deasserting req of the owner mid-burst SHALL NOT abort the burst; requests of the non-owner are ignored until IDLE.
REQ-028 Requesting a read beat address just written by the same burst SHALL return the newly written data (RAM ordering), no forwarding required.

Reset
REQ-029 While reset is high at a clock edge, the FSM SHALL go to IDLE, priority to requester 0, address and beat counters to 0, and all outputs except rdata to 0 on the following cycle, including mid-burst; the aborted burst SHALL produce no done pulse.

Verification
REQ-030 Single write: req_0, we_0=1, addr_0=0x3FE, len_0=2, wdata 0xA,0xB,0xC -> writes at 0x3FE, 0x3FF, 0x000 (wrap), wrdy_0 three cycles, done_0 one pulse.
REQ-031 Read-back: req_1 read addr 0x3FE len 2 -> rvld_1 three cycles with rdata 0xA,0xB,0xC in order, done_1 with last rvld.
REQ-032 Contention: req_0 and req_1 both high from reset -> gnt_0 first, gnt_1 second, then with both still requesting gnt_0 again (alternation).
REQ-033 Length extremes: len=0 -> one beat, 3-cycle occupancy; len=15 -> 16 beats, 18-cycle occupancy.
REQ-034 Reset mid-burst: reset on 3rd beat of len=7 write -> next cycle all outputs 0, state IDLE, no done; later only beats 0-2 present in RAM.
REQ-035 Owner drops req mid-burst -> burst still completes all len+1 beats and done.
